cla_pipe_adder: RTL

Pipelined, parametrised two's-complement adder/subtractor. Its carry network is the recursive carry-lookahead tree of `INPUT_SIZE`-wide carry generators, `DEPTH` levels deep. It adds a 2-stage register pipeline, a valid/ready handshake with backpressure, add/subtract modes and status flags. It sits between operand producers and the datapath as a fixed-latency, full-throughput arithmetic unit.

---
 rtl/cla_pipe_adder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined add/subtract unit with a recursive
// carry-lookahead tree, valid/ready handshake and carry/overflow/zero flags.

// One node of the lookahead tree. A node of depth D covers INPUT_SIZE**D bits.
// It returns group generate/propagate to its parent and hands each child its
// carry-in. Depth 0 is a single bit.
module cla_node #(
  parameter int INPUT_SIZE = 4,
  parameter int D          = 1,
  localparam int N         = INPUT_SIZE ** D
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  input  logic         cin,
  output logic [N-1:0] c,
  output logic         gg,
  output logic         pg
);

  if (D == 0) begin : g_leaf
    // A single bit: its carry-in is the carry into that bit position.
    assign c  = cin;
    assign gg = g[0];
    assign pg = p[0];
  end else begin : g_inner
    localparam int M = N / INPUT_SIZE;

    logic [INPUT_SIZE-1:0] sg;
    logic [INPUT_SIZE-1:0] sp;
    logic [INPUT_SIZE-1:0] sc;

    for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_child
      cla_node #(
        .INPUT_SIZE(INPUT_SIZE),
        .D         (D - 1)
      ) u_child (
        .g  (g[i*M +: M]),
        .p  (p[i*M +: M]),
        .cin(sc[i]),
        .c  (c[i*M +: M]),
        .gg (sg[i]),
        .pg (sp[i])
      );
    end

    // Lookahead generator: carry into child i is the prefix G/P of children
    // 0..i-1 applied to cin. Written as a prefix loop; each term is a
    // two-level sum of products once unrolled.
    always_comb begin
      // NOTE: every variable written here gets a value before any branch or
      // loop, so no path can leave it holding a stale value (no latch).
      sc = '0;
      gg = 1'b0;
      pg = 1'b1;
      for (int i = 0; i < INPUT_SIZE; i++) begin
        sc[i] = gg | (pg & cin);
        gg    = sg[i] | (sp[i] & gg);
        pg    = pg & sp[i];
      end
    end
  end

endmodule

module cla_pipe_adder #(
  parameter int INPUT_SIZE = 4,
  parameter int DEPTH      = 2,
  localparam int W         = INPUT_SIZE ** DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_ADC = 2'd2,
    MODE_SBB = 2'd3
  } mode_e;

  // Operand conditioning.
  logic [W-1:0] b_cond;
  logic         c0;

  // Stage 1 registers.
  logic         s1_v;
  logic [W-1:0] s1_g;
  logic [W-1:0] s1_p;
  logic         s1_c0;
  logic         s1_a_sign;
  logic         s1_b_sign;

  // Stage 2 combinational results.
  logic [W-1:0] carry_into;
  logic         tree_g;
  logic         tree_p;
  logic [W-1:0] sum_nxt;
  logic         cout_nxt;
  logic         ovf_nxt;

  // Pipeline control.
  logic         s2_v;
  logic         s1_load;
  logic         s2_load;

  assign s2_load   = !s2_v || out_ready;
  assign s1_load   = !s1_v || s2_load;
  // Combinational from out_ready so a full pipeline still streams at full rate.
  assign in_ready  = !s1_v || !s2_v || out_ready;
  assign out_valid = s2_v;

  // Subtraction inverts B and injects the +1 (or the inverted borrow) as c0.
  always_comb begin
    b_cond = in_b;
    c0     = 1'b0;
    case (mode_e'(in_mode))
      MODE_ADD: begin b_cond = in_b;  c0 = 1'b0;    end
      MODE_SUB: begin b_cond = ~in_b; c0 = 1'b1;    end
      MODE_ADC: begin b_cond = in_b;  c0 = in_cin;  end
      MODE_SBB: begin b_cond = ~in_b; c0 = ~in_cin; end
      default:  begin b_cond = in_b;  c0 = 1'b0;    end
    endcase
  end

  // Stage 1: capture per-bit generate/propagate, c0 and operand signs.
  always_ff @(posedge clk) begin
    // NOTE: data registers are cleared in reset too, so out_* and the
    // pipeline contents read as zero after reset rather than stale beats.
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_g      <= '0;
      s1_p      <= '0;
      s1_c0     <= 1'b0;
      s1_a_sign <= 1'b0;
      s1_b_sign <= 1'b0;
    end else if (s1_load) begin
      // NOTE: sequential state uses <= so every register samples the values
      // from before this edge, independent of statement order.
      s1_v <= in_valid;
      if (in_valid) begin
        s1_g      <= in_a & b_cond;
        s1_p      <= in_a ^ b_cond;
        s1_c0     <= c0;
        s1_a_sign <= in_a[W-1];
        s1_b_sign <= b_cond[W-1];
      end
    end
  end

  // Stage 2 carry network: the whole lookahead tree sits in this cycle.
  cla_node #(
    .INPUT_SIZE(INPUT_SIZE),
    .D         (DEPTH)
  ) u_tree (
    .g  (s1_g),
    .p  (s1_p),
    .cin(s1_c0),
    .c  (carry_into),
    .gg (tree_g),
    .pg (tree_p)
  );

  // carry_into[i] is the carry into bit i, i.e. {carry[W-2:0], c0}.
  assign sum_nxt  = s1_p ^ carry_into;
  assign cout_nxt = tree_g | (tree_p & s1_c0);
  assign ovf_nxt  = (s1_a_sign == s1_b_sign) && (sum_nxt[W-1] != s1_a_sign);

  // Stage 2: register the result and flags; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_sum  <= sum_nxt;
        out_cout <= cout_nxt;
        out_ovf  <= ovf_nxt;
        out_zero <= ~|sum_nxt;
      end
    end
  end

endmodule
